// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: multiplexed TDM input stream and recovered per-channel outputs.
interface tdm_demux4_if #(parameter int WIDTH = 1);
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               frame_sync;
    logic [WIDTH-1:0]   y0, y1, y2, y3;
    logic [3:0]         y_strobe;
    logic [4*WIDTH-1:0] frame_out;
    logic               frame_done;
    logic               sync_err;
    logic               locked;
    modport master (output din, din_valid, frame_sync,
                    input  y0, y1, y2, y3, y_strobe, frame_out, frame_done, sync_err, locked);
    modport slave  (input  din, din_valid, frame_sync,
                    output y0, y1, y2, y3, y_strobe, frame_out, frame_done, sync_err, locked);
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-channel TDM demultiplexer with slot-0 sync lock, atomic frame
// publication and framing-error detection.
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input logic          clk,
    input logic          rst,
    tdm_demux4_if.slave  bus
);
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t               r_state, w_state;
    logic [1:0]           r_slot, w_slot;
    logic [WIDTH-1:0]     r_y [4];
    logic [WIDTH-1:0]     w_y [4];
    logic [WIDTH-1:0]     r_stg [3];
    logic [WIDTH-1:0]     w_stg [3];
    logic [4*WIDTH-1:0]   r_frame, w_frame;
    logic [3:0]           r_strobe, w_strobe;
    logic                 r_done, w_done, r_err, w_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= HUNT;
            r_slot   <= '0;
            r_y      <= '{default: '0};
            r_stg    <= '{default: '0};
            r_frame  <= '0;
            r_strobe <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_slot   <= w_slot;
            r_y      <= w_y;
            r_stg    <= w_stg;
            r_frame  <= w_frame;
            r_strobe <= w_strobe;
            r_done   <= w_done;
            r_err    <= w_err;
        end
    end
    always_comb begin
        w_state  = r_state;
        w_slot   = r_slot;
        w_y      = r_y;
        w_stg    = r_stg;
        w_frame  = r_frame;
        w_strobe = '0;
        w_done   = 1'b0;
        w_err    = 1'b0;
        if (bus.din_valid) begin
            // A sync-qualified sample always starts a new frame, in either state.
            if (bus.frame_sync) begin
                w_err    = (r_state == LOCKED) && (r_slot != 2'd0);
                w_y[0]   = bus.din;
                w_stg[0] = bus.din;
                w_strobe = 4'b0001;
                w_slot   = 2'd1;
                w_state  = LOCKED;
            end else if (r_state == LOCKED && r_slot == 2'd0) begin
                w_err   = 1'b1;
                w_state = HUNT;
            end else if (r_state == LOCKED) begin
                w_y[r_slot] = bus.din;
                w_strobe    = 4'b0001 << r_slot;
                w_slot      = r_slot + 2'd1;
                if (r_slot == 2'd3) begin
                    w_frame = {bus.din, r_stg[2], r_stg[1], r_stg[0]};
                    w_done  = 1'b1;
                end else begin
                    w_stg[r_slot] = bus.din;
                end
            end
        end
    end
    assign bus.y0         = r_y[0];
    assign bus.y1         = r_y[1];
    assign bus.y2         = r_y[2];
    assign bus.y3         = r_y[3];
    assign bus.y_strobe   = r_strobe;
    assign bus.frame_out  = r_frame;
    assign bus.frame_done = r_done;
    assign bus.sync_err   = r_err;
    assign bus.locked     = (r_state == LOCKED);
endmodule
